// File: rtl/fetch_pkg.sv
// Shared constants for the fetch-to-decode buffer: default widths, the bubble
// word, lane-valid encodings and the PC step between adjacent fetched words.
package fetch_pkg;

    localparam int IW_DEF = 32;
    localparam int PW_DEF = 32;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          PC_INC   = 4;

    // 2'b10 is deliberately absent: a younger word without its older partner is not legal
    typedef enum logic [1:0] {
        LANE_NONE = 2'b00,
        LANE_ONE  = 2'b01,
        LANE_TWO  = 2'b11
    } lane_e;

endpackage

// File: rtl/fetch_buf_mem.sv
// Circular storage for the fetch buffer: two write ports for the fetch pair
// and two asynchronous read ports for the decode slot pair.
module fetch_buf_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] wa0_i,
    input  logic [AW-1:0] wa1_i,
    input  logic [W-1:0]  wd0_i,
    input  logic [W-1:0]  wd1_i,
    input  logic [AW-1:0] ra0_i,
    input  logic [AW-1:0] ra1_i,
    output logic [W-1:0]  rd0_o,
    output logic [W-1:0]  rd1_o
);

    logic [W-1:0] mem_q [DEPTH];

    // No reset: consumers mask unoccupied entries, so stale contents never escape
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[wa0_i] <= wd0_i;
        if (we1_i) mem_q[wa1_i] <= wd1_i;
    end

    assign rd0_o = mem_q[ra0_i];
    assign rd1_o = mem_q[ra1_i];

endmodule

// File: rtl/dual_fetch_buffer.sv
// Buffers 0-2 fetched words per cycle and presents the two oldest, in program
// order, as the slot pair feeding the dual decoder.
module dual_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter int              IW       = IW_DEF,
    parameter int              PW       = PW_DEF,
    parameter logic [IW-1:0]   NOP_WORD = fetch_pkg::NOP_WORD,
    localparam int             AW       = $clog2(DEPTH),
    localparam int             CW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    in_valid,
    input  logic [IW-1:0] in_instr0,
    input  logic [IW-1:0] in_instr1,
    input  logic [PW-1:0] in_pc,
    output logic          in_ready,
    output logic          out_valid1,
    output logic          out_valid2,
    output logic [IW-1:0] instr1,
    output logic [IW-1:0] instr2,
    output logic [PW-1:0] pc1,
    output logic [PW-1:0] pc2,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam int W = IW + PW;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    push_n, pop_n;
    logic [W-1:0]  rd0, rd1;

    // Space check uses only the registered count; a same-cycle pop never frees room
    assign in_ready   = (count_q <= CW'(DEPTH - 2));
    assign out_valid1 = (count_q >= CW'(1));
    assign out_valid2 = (count_q >= CW'(2));
    assign count      = count_q;

    always_comb begin
        push_n = 2'd0;
        if (in_ready && !flush) begin
            case (in_valid)
                LANE_ONE: push_n = 2'd1;
                LANE_TWO: push_n = 2'd2;
                default:  push_n = 2'd0;
            endcase
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (!flush && out_ready)
            pop_n = {1'b0, out_valid1} + {1'b0, out_valid2};
    end

    always_comb begin
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_buf_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we0_i (push_n != 2'd0),
        .we1_i (push_n == 2'd2),
        .wa0_i (tail_q),
        .wa1_i (tail_q + AW'(1)),
        .wd0_i ({in_pc, in_instr0}),
        .wd1_i ({in_pc + PW'(PC_INC), in_instr1}),
        .ra0_i (head_q),
        .ra1_i (head_q + AW'(1)),
        .rd0_o (rd0),
        .rd1_o (rd1)
    );

    // Unoccupied slots are forced to a bubble so storage garbage never reaches decode
    assign instr1 = out_valid1 ? rd0[IW-1:0]   : NOP_WORD;
    assign pc1    = out_valid1 ? rd0[W-1:IW]   : '0;
    assign instr2 = out_valid2 ? rd1[IW-1:0]   : NOP_WORD;
    assign pc2    = out_valid2 ? rd1[W-1:IW]   : '0;

endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Directed and randomized checks of dual_fetch_buffer against a queue model.
module tb_dual_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, out_ready;
    logic [1:0]    in_valid;
    logic [31:0]   in_instr0, in_instr1, in_pc;
    logic          in_ready, out_valid1, out_valid2;
    logic [31:0]   instr1, instr2, pc1, pc2;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;

    logic [63:0] q[$];          // {instr, pc}, oldest first
    bit          armed = 0;
    bit          track = 0;
    bit          have_last = 0;
    logic [31:0] last_pc;
    logic [31:0] pcnt = 32'h0;

    always #5 clk = ~clk;

    dual_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid1(out_valid1), .out_valid2(out_valid2),
        .instr1(instr1), .instr2(instr2), .pc1(pc1), .pc2(pc2),
        .out_ready(out_ready), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n = q.size();
        chk("count",  64'(count), 64'(n));
        chk("in_rdy", 64'(in_ready), 64'(DEPTH - n >= 2));
        chk("v1",     64'(out_valid1), 64'(n >= 1));
        chk("v2",     64'(out_valid2), 64'(n >= 2));
        chk("instr1", 64'(instr1), (n >= 1) ? 64'(q[0][63:32]) : 64'h0);
        chk("pc1",    64'(pc1),    (n >= 1) ? 64'(q[0][31:0])  : 64'h0);
        chk("instr2", 64'(instr2), (n >= 2) ? 64'(q[1][63:32]) : 64'h0);
        chk("pc2",    64'(pc2),    (n >= 2) ? 64'(q[1][31:0])  : 64'h0);
    endtask

    // One clock: drive at negedge, check registered outputs, then advance the model
    task automatic cyc(input logic r, input logic f, input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input logic ordy);
        int npop;
        bit can_push;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_instr0 = i0; in_instr1 = i1;
        in_pc = pc; out_ready = ordy;
        #1;
        if (armed) check_model();
        if (armed && track && ordy && !f && !r) begin
            if (out_valid1) begin
                if (have_last) chk("t4_seq", 64'(pc1), 64'(last_pc + 32'd4));
                last_pc = pc1; have_last = 1;
            end
            if (out_valid2) begin
                chk("t4_seq", 64'(pc2), 64'(last_pc + 32'd4));
                last_pc = pc2;
            end
        end
        can_push = (DEPTH - q.size() >= 2);
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            npop = ordy ? ((q.size() > 2) ? 2 : q.size()) : 0;
            repeat (npop) void'(q.pop_front());
            if (can_push && (v == 2'b01 || v == 2'b11)) q.push_back({i0, pc});
            if (can_push && v == 2'b11) q.push_back({i1, pc + 32'd4});
        end
    endtask

    task automatic idle(input logic ordy);
        cyc(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, ordy);
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_instr0 = 0; in_instr1 = 0; in_pc = 0; out_ready = 0;
        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        armed = 1;

        // 1: pair push then pop both
        idle(0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_inrdy", 64'(in_ready), 64'h1);
        cyc(0, 0, 2'b11, 32'hAAAA0001, 32'hAAAA0002, 32'h100, 0);
        #2;
        chk("t1_pc1", 64'(pc1), 64'h100);
        chk("t1_pc2", 64'(pc2), 64'h104);
        chk("t1_i2",  64'(instr2), 64'hAAAA0002);
        chk("t1_cnt", 64'(count), 64'h2);
        idle(1);
        #2 chk("t1_drain", 64'(count), 64'h0);

        // 2: single word, slot 2 must be a bubble
        cyc(0, 0, 2'b01, 32'h11, 32'hDEAD, 32'h200, 0);
        #2;
        chk("t2_v2", 64'(out_valid2), 64'h0);
        chk("t2_i2", 64'(instr2), 64'h0);
        chk("t2_i1", 64'(instr1), 64'h11);
        idle(1);
        #2 chk("t2_cnt", 64'(count), 64'h0);

        // 3: fill to DEPTH, further push ignored
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 2'b11, 32'hB000 + 32'(2*k), 32'hB001 + 32'(2*k), 32'h300 + 32'(8*k), 0);
        #2;
        chk("t3_full", 64'(count), 64'h8);
        chk("t3_rdy",  64'(in_ready), 64'h0);
        cyc(0, 0, 2'b11, 32'hBAD0, 32'hBAD1, 32'h400, 0);
        #2 chk("t3_hold", 64'(count), 64'h8);
        repeat (5) idle(1);

        // 4: streaming with wrap-around, popped PCs strictly +4
        track = 1; have_last = 0;
        for (int k = 0; k < 20; k++)
            cyc(0, 0, 2'b11, 32'hC000 + 32'(k), 32'hC100 + 32'(k), 32'(8*k), 1);
        repeat (6) idle(1);
        track = 0;
        chk("t4_last", 64'(last_pc), 64'h9C);

        // 5: flush beats a simultaneous push and pop
        cyc(0, 0, 2'b11, 32'hD0, 32'hD1, 32'h500, 0);
        cyc(0, 0, 2'b11, 32'hD2, 32'hD3, 32'h508, 0);
        cyc(0, 0, 2'b01, 32'hD4, 32'hD5, 32'h510, 0);
        #2 chk("t5_five", 64'(count), 64'h5);
        cyc(0, 1, 2'b11, 32'hE0, 32'hE1, 32'h600, 1);
        #2;
        chk("t5_cnt", 64'(count), 64'h0);
        chk("t5_v1",  64'(out_valid1), 64'h0);
        chk("t5_rdy", 64'(in_ready), 64'h1);
        repeat (2) idle(1);

        // 6: illegal lane pattern, then reset with content
        cyc(0, 0, 2'b10, 32'hF0, 32'hF1, 32'h700, 0);
        #2 chk("t6_ill", 64'(count), 64'h0);
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 2'b11, 32'hF10 + 32'(k), 32'hF20 + 32'(k), 32'h800 + 32'(8*k), 0);
        cyc(0, 0, 2'b10, 32'hF0, 32'hF1, 32'h700, 0);
        #2 chk("t6_six", 64'(count), 64'h6);
        cyc(1, 0, 2'b11, 32'hF30, 32'hF31, 32'h900, 1);
        #2;
        chk("t6_rcnt", 64'(count), 64'h0);
        chk("t6_rpc1", 64'(pc1), 64'h0);
        chk("t6_ri1",  64'(instr1), 64'h0);
        chk("t6_rv2",  64'(out_valid2), 64'h0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [1:0] v;
            int sel = $urandom_range(0, 9);
            v = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 9) ? 2'b11 : 2'b10;
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0), v,
                $urandom, $urandom, pcnt, ($urandom_range(0, 2) != 0));
            pcnt = pcnt + 32'd8;
        end
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
